cover_toggle_collector: RTL

Parametrised toggle-coverage collector that replaces the per-bit fire-every-cycle reporters with a sticky, deduplicating, serialising engine. It records the first hit of each of WIDTH toggle points, keeps a count of distinct points covered, and drains newly covered points one per cycle as absolute cover indices over a valid/ready stream. The block sits between the coverage instrumentation and the single coverage sink (DPI bridge or formal monitor).

---
 rtl/cover_toggle_collector_if.sv | 28 ++
 rtl/cover_toggle_collector.sv | 85 ++++++++
 2 files changed

// File: rtl/cover_toggle_collector_if.sv
// Coverage collector bus: hit sampling inputs plus the drained-index stream.
//   master : instrumentation/sink side (drives en, clear, valid, out_ready)
//   slave  : collector side (drives out_valid, out_index, hit_count, all_covered, pending_any)
interface cover_toggle_collector_if #(
    parameter int unsigned WIDTH = 65,
    parameter int unsigned IDX_W = 64,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
);
    logic             en;
    logic             clear;
    logic [WIDTH-1:0] valid;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_index;
    logic [CNT_W-1:0] hit_count;
    logic             all_covered;
    logic             pending_any;

    modport master (
        output en, clear, valid, out_ready,
        input  out_valid, out_index, hit_count, all_covered, pending_any
    );

    modport slave (
        input  en, clear, valid, out_ready,
        output out_valid, out_index, hit_count, all_covered, pending_any
    );
endinterface

// File: rtl/cover_toggle_collector.sv
// Sticky, deduplicating toggle-coverage collector. Records the first hit of each of
// WIDTH points, counts distinct points covered and drains newly covered points one
// per cycle, lowest index first, as absolute cover indices on a valid/ready stream.
// Ports:
//   gbl_clk : clock
//   reset   : synchronous, active-low reset
//   cov     : collector bus (slave): en, clear, valid in; out_ready in;
//             out_valid, out_index, hit_count, all_covered, pending_any out
module cover_toggle_collector #(
    parameter int unsigned WIDTH       = 65,
    parameter int unsigned COVER_INDEX = 0,
    parameter int unsigned COVER_TOTAL = 8940,
    parameter int unsigned IDX_W       = 64,
    parameter int unsigned CNT_W       = $clog2(WIDTH + 1)
) (
    input logic                     gbl_clk,
    input logic                     reset,
    cover_toggle_collector_if.slave cov
);
    localparam int unsigned KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_range_check
        $error("cover_toggle_collector: COVER_INDEX+WIDTH exceeds COVER_TOTAL");
    end

    logic [WIDTH-1:0] r_covered;
    logic [WIDTH-1:0] r_pending;
    logic [CNT_W-1:0] r_hit_count;
    logic             r_out_valid;
    logic [IDX_W-1:0] r_out_index;

    logic [WIDTH-1:0] w_new;
    logic [WIDTH-1:0] w_low;
    logic [CNT_W-1:0] w_new_count;
    logic [KW-1:0]    w_low_idx;
    logic             w_load;

    always_comb begin
        w_new = cov.en ? (cov.valid & ~r_covered) : '0;
        // Isolate the lowest set pending bit (two's-complement trick).
        w_low = r_pending & (~r_pending + WIDTH'(1));
        w_new_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_new_count = w_new_count + CNT_W'(w_new[i]);
        end
        // Scan downward so the last assignment is the lowest set index.
        w_low_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_low_idx = KW'(i);
            end
        end
        w_load = !r_out_valid || cov.out_ready;
    end

    always_ff @(posedge gbl_clk) begin
        if (!reset || cov.clear) begin
            r_covered   <= '0;
            r_pending   <= '0;
            r_hit_count <= '0;
            r_out_valid <= 1'b0;
            r_out_index <= '0;
        end else begin
            r_covered   <= r_covered | w_new;
            // Cannot overflow: each point contributes at most once between clears.
            r_hit_count <= r_hit_count + w_new_count;
            if (w_load) begin
                // New hits are never already pending, so set and clear never collide.
                r_pending   <= (r_pending & ~w_low) | w_new;
                r_out_valid <= |r_pending;
                if (|r_pending) begin
                    r_out_index <= IDX_W'(COVER_INDEX) + IDX_W'(w_low_idx);
                end
            end else begin
                r_pending <= r_pending | w_new;
            end
        end
    end

    assign cov.out_valid   = r_out_valid;
    assign cov.out_index   = r_out_index;
    assign cov.hit_count   = r_hit_count;
    assign cov.all_covered = (r_hit_count == CNT_W'(WIDTH));
    assign cov.pending_any = |r_pending;
endmodule
